// File: rtl/sram_arb_pkg.sv
// Shared types and encodings for the two-master sram-like arbiter.
package sram_arb_pkg;

    typedef logic master_id_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam master_id_t ID_M0 = 1'b0;
    localparam master_id_t ID_M1 = 1'b1;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// Issue-order FIFO of master IDs for outstanding sram-like transactions.
// Latency: head_id/count update one cycle after push/pop; head_id is a plain register read.
// Backpressure: push ignored when full, pop ignored when empty; the caller gates on full.
module sram_arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  master_id_t    push_id,
    output master_id_t    head_id,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0] id_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_eff;
    logic             pop_eff;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_eff = push && !full;
    assign pop_eff  = pop && !empty;
    assign head_id  = id_q[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                id_q[wr_ptr] <= push_id;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter; round-robin, or m0-priority with SRAM_ARB_FIXED_PRIO_EN.
// Latency: zero added on request, addr_ok and data_ok paths (all combinational).
// Backpressure: s_req drops while DEPTH transactions are outstanding; grant locks until addr_ok.
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [1:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_addr_ok,
    output logic          m0_data_ok,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [1:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_addr_ok,
    output logic          m1_data_ok,
    output logic [DW-1:0] m1_rdata,

    output logic          s_req,
    output logic          s_wr,
    output logic [1:0]    s_size,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_addr_ok,
    input  logic          s_data_ok,
    input  logic [DW-1:0] s_rdata,

    output logic          err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          lock;
    master_id_t    lock_id;
    master_id_t    rr_ptr;
    master_id_t    grant;
    master_id_t    head_id;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          gnt_req;
    logic          addr_hs;
    logic          pop_vld;

    always_comb begin
        grant = rr_ptr;
        if (lock) begin
            grant = lock_id;
        end else if (m0_req && !m1_req) begin
            grant = ID_M0;
        end else if (m1_req && !m0_req) begin
            grant = ID_M1;
        end else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            grant = ID_M0;
`else
            grant = rr_ptr;
`endif
        end
    end

    assign gnt_req = (grant == ID_M1) ? m1_req : m0_req;
    // Full is taken from the registered count so a same-cycle pop cannot loop data_ok into s_req.
    assign s_req   = gnt_req && !fifo_full;
    assign s_wr    = (grant == ID_M1) ? m1_wr    : m0_wr;
    assign s_size  = (grant == ID_M1) ? m1_size  : m0_size;
    assign s_addr  = (grant == ID_M1) ? m1_addr  : m0_addr;
    assign s_wdata = (grant == ID_M1) ? m1_wdata : m0_wdata;

    assign addr_hs    = s_req && s_addr_ok;
    assign m0_addr_ok = !reset && addr_hs && (grant == ID_M0);
    assign m1_addr_ok = !reset && addr_hs && (grant == ID_M1);

    assign pop_vld    = s_data_ok && !fifo_empty;
    assign m0_data_ok = !reset && pop_vld && (head_id == ID_M0);
    assign m1_data_ok = !reset && pop_vld && (head_id == ID_M1);
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    sram_arb_id_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (addr_hs),
        .pop     (s_data_ok),
        .push_id (grant),
        .head_id (head_id),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Request fields must hold until addr_ok, so a stalled grant is pinned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_id <= ID_M0;
            rr_ptr  <= ID_M0;
            err     <= 1'b0;
        end else begin
            if (addr_hs) begin
                lock <= 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
                rr_ptr <= ID_M0;
`else
                rr_ptr <= ~grant;
`endif
            end else if (s_req) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end
            if (s_data_ok && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed-vector bench for sram_like_arbiter (DEPTH = 2).
module tb_sram_like_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
    logic [1:0]    m0_size = 2'd2, m1_size = 2'd2;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_req, s_wr;
    logic [1:0]    s_size;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_addr_ok = 0, s_data_ok = 0;
    logic [DW-1:0] s_rdata = '0;
    logic          err;

    int n_vec = 0;
    int n_bad = 0;

    sram_like_arbiter #(.AW(AW), .DW(DW), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; m0_req = 1; s_addr_ok = 1; s_data_ok = 1;
        #2;
        n_vec++;
        if ({m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} !== 4'b0) begin
            n_bad++; $display("FAIL reset_oks: got %b want 0000", {m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok});
        end
        n_vec++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_bad++; $display("FAIL reset_sreq: got req=%b addr=%h want 1/100", s_req, s_addr);
        end
        n_vec++;
        if (err !== 1'b0 || dut.u_fifo.count !== 2'd0) begin
            n_bad++; $display("FAIL reset_state: got err=%b count=%0d want 0/0", err, dut.u_fifo.count);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_addr = 32'h1FC0_0000; s_addr_ok = 1;
        #2;
        n_vec++;
        if (m0_addr_ok !== 1'b1 || m1_addr_ok !== 1'b0 || s_addr !== 32'h1FC0_0000) begin
            n_bad++; $display("FAIL read_addr_ok: got m0=%b m1=%b addr=%h want 1/0/1fc00000", m0_addr_ok, m1_addr_ok, s_addr);
        end
        tick();
        m0_req = 0; s_addr_ok = 0;
        for (int c = 1; c < 3; c++) begin
            #2;
            n_vec++;
            if (m0_data_ok !== 1'b0 || m1_data_ok !== 1'b0) begin
                n_bad++; $display("FAIL read_early c%0d: got %b%b want 00", c, m0_data_ok, m1_data_ok);
            end
            tick();
        end
        s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
        #2;
        n_vec++;
        if (m0_data_ok !== 1'b1 || m1_data_ok !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL read_data_ok: got m0=%b m1=%b rdata=%h want 1/0/deadbeef", m0_data_ok, m1_data_ok, m0_rdata);
        end
        tick();
        idle();
    endtask

    task automatic test_contention();
        logic exp_g;
        logic prev_g;
        do_reset();
        m0_req = 1; m1_req = 1; s_addr_ok = 1;
        prev_g = 0;
        for (int c = 0; c < 4; c++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = c[0];
`endif
            s_data_ok = (c > 0);
            #2;
            n_vec++;
            if (m0_addr_ok !== !exp_g || m1_addr_ok !== exp_g || s_addr !== (exp_g ? 32'h200 : 32'h100)) begin
                n_bad++; $display("FAIL contention_grant c%0d: got ok=%b%b addr=%h want grant m%0d", c, m0_addr_ok, m1_addr_ok, s_addr, exp_g);
            end
            if (c > 0) begin
                n_vec++;
                if (m0_data_ok !== !prev_g || m1_data_ok !== prev_g) begin
                    n_bad++; $display("FAIL contention_pop c%0d: got %b%b want data_ok to m%0d", c, m0_data_ok, m1_data_ok, prev_g);
                end
            end
            prev_g = exp_g;
            tick();
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        m1_req = 1; m1_wr = 1; m1_size = 2'd1; m1_wdata = 32'h5A5A_0001;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) m0_req = 1;
            #2;
            n_vec++;
            if (s_req !== 1'b1 || s_addr !== 32'h200 || s_wr !== 1'b1 || s_size !== 2'd1 ||
                s_wdata !== 32'h5A5A_0001 || m0_addr_ok !== 1'b0 || m1_addr_ok !== 1'b0) begin
                n_bad++; $display("FAIL lock_hold c%0d: got req=%b addr=%h wr=%b size=%0d ok=%b%b want m1 request held", c, s_req, s_addr, s_wr, s_size, m0_addr_ok, m1_addr_ok);
            end
            tick();
        end
        s_addr_ok = 1;
        #2;
        n_vec++;
        if (m1_addr_ok !== 1'b1 || m0_addr_ok !== 1'b0 || s_addr !== 32'h200) begin
            n_bad++; $display("FAIL lock_accept: got ok=%b%b addr=%h want 01/200", m0_addr_ok, m1_addr_ok, s_addr);
        end
        tick();
        m1_req = 0; m1_wr = 0; m1_size = 2'd2;
        #2;
        n_vec++;
        if (m0_addr_ok !== 1'b1 || s_addr !== 32'h100 || s_wr !== 1'b0) begin
            n_bad++; $display("FAIL lock_next: got m0_ok=%b addr=%h wr=%b want 1/100/0", m0_addr_ok, s_addr, s_wr);
        end
        tick();
        idle();
    endtask

    // Leaves two accepted transactions (m0 then m1) outstanding.
    task automatic fill_two();
        m0_req = 1; s_addr_ok = 1;
        tick();
        m0_req = 0; m1_req = 1;
        tick();
        m1_req = 0;
    endtask

    task automatic test_full();
        do_reset();
        fill_two();
        m0_req = 1; s_addr_ok = 1;
        #2;
        n_vec++;
        if (s_req !== 1'b0 || m0_addr_ok !== 1'b0 || m1_addr_ok !== 1'b0 || dut.u_fifo.count !== 2'd2) begin
            n_bad++; $display("FAIL full_block: got req=%b ok=%b%b count=%0d want 0/00/2", s_req, m0_addr_ok, m1_addr_ok, dut.u_fifo.count);
        end
        tick();
        s_data_ok = 1; s_rdata = 32'h1111_1111;
        #2;
        n_vec++;
        if (m0_data_ok !== 1'b1 || m1_data_ok !== 1'b0 || s_req !== 1'b0 || m0_rdata !== 32'h1111_1111) begin
            n_bad++; $display("FAIL full_pop1: got dok=%b%b req=%b rdata=%h want 10/0/11111111", m0_data_ok, m1_data_ok, s_req, m0_rdata);
        end
        tick();
        s_rdata = 32'h2222_2222;
        #2;
        n_vec++;
        if (m1_data_ok !== 1'b1 || m0_data_ok !== 1'b0 || s_req !== 1'b1 || m0_addr_ok !== 1'b1 || m1_rdata !== 32'h2222_2222) begin
            n_bad++; $display("FAIL full_resume: got dok=%b%b req=%b m0_ok=%b want 01/1/1", m0_data_ok, m1_data_ok, s_req, m0_addr_ok);
        end
        tick();
        idle();
    endtask

    task automatic test_simul();
        do_reset();
        m0_req = 1; s_addr_ok = 1;
        tick();
        m0_req = 0; m1_req = 1; s_data_ok = 1; s_rdata = 32'h0000_00AB;
        #2;
        n_vec++;
        if (m1_addr_ok !== 1'b1 || m0_data_ok !== 1'b1 || m1_data_ok !== 1'b0) begin
            n_bad++; $display("FAIL simul_pushpop: got m1_ok=%b dok=%b%b want 1/10", m1_addr_ok, m0_data_ok, m1_data_ok);
        end
        tick();
        m1_req = 0; s_addr_ok = 0;
        n_vec++;
        if (dut.u_fifo.count !== 2'd1) begin
            n_bad++; $display("FAIL simul_count: got %0d want 1", dut.u_fifo.count);
        end
        #2;
        n_vec++;
        if (m1_data_ok !== 1'b1 || m0_data_ok !== 1'b0) begin
            n_bad++; $display("FAIL simul_second: got dok=%b%b want 01", m0_data_ok, m1_data_ok);
        end
        tick();
        idle();
    endtask

    task automatic test_error_reset();
        do_reset();
        s_data_ok = 1;
        #2;
        n_vec++;
        if (m0_data_ok !== 1'b0 || m1_data_ok !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL err_pop_empty: got dok=%b%b err=%b want 00/0", m0_data_ok, m1_data_ok, err);
        end
        tick();
        s_data_ok = 0;
        tick();
        tick();
        n_vec++;
        if (err !== 1'b1 || dut.u_fifo.count !== 2'd0) begin
            n_bad++; $display("FAIL err_sticky: got err=%b count=%0d want 1/0", err, dut.u_fifo.count);
        end
        do_reset();
        fill_two();
        m0_req = 1; s_addr_ok = 1; s_data_ok = 1;
        reset = 1;
        #2;
        n_vec++;
        if (dut.u_fifo.count !== 2'd0 || {m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} !== 4'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: got count=%0d oks=%b err=%b want 0/0000/0", dut.u_fifo.count, {m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, err);
        end
        tick();
        reset = 0; m0_req = 0; s_addr_ok = 0;
        #2;
        n_vec++;
        if (m0_data_ok !== 1'b0 || m1_data_ok !== 1'b0) begin
            n_bad++; $display("FAIL stale_dok: got %b%b want 00", m0_data_ok, m1_data_ok);
        end
        tick();
        n_vec++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL stale_err: got %b want 1", err);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_full();
        test_simul();
        test_error_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
